// File: rtl/iterative_alu.sv
`default_nettype none
// ============================================================================
// Module   : iterative_alu
// Purpose  : Handshaked ALU. Single-cycle ops (add/sub, logic, compares and
//            shifts) register their result at the accept edge. MUL/MULHU use
//            an iterative shift-add multiplier and DIVU/REMU a restoring
//            divider, one step per cycle for WIDTH cycles.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            in_valid/ready  - operation handshake (op, operand_a, operand_b)
//            out_valid/ready - result handshake (result + flags)
//            result          - registered operation result
//            is_zero         - result == 0
//            is_negative     - result MSB
//            illegal_op      - op code 14/15 was issued
//            div_by_zero     - DIVU/REMU issued with operand_b == 0
// Revision : 1.0 - initial release
// ============================================================================
module iterative_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             is_zero,
    output logic             is_negative,
    output logic             illegal_op,
    output logic             div_by_zero
);

    localparam int SH_W = $clog2(WIDTH);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_busy = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    localparam logic [3:0] c_op_add   = 4'd0;
    localparam logic [3:0] c_op_sub   = 4'd1;
    localparam logic [3:0] c_op_and   = 4'd2;
    localparam logic [3:0] c_op_or    = 4'd3;
    localparam logic [3:0] c_op_xor   = 4'd4;
    localparam logic [3:0] c_op_slt   = 4'd5;
    localparam logic [3:0] c_op_sltu  = 4'd6;
    localparam logic [3:0] c_op_sll   = 4'd7;
    localparam logic [3:0] c_op_srl   = 4'd8;
    localparam logic [3:0] c_op_sra   = 4'd9;
    localparam logic [3:0] c_op_mul   = 4'd10;
    localparam logic [3:0] c_op_mulhu = 4'd11;
    localparam logic [3:0] c_op_divu  = 4'd12;
    localparam logic [3:0] c_op_remu  = 4'd13;

    localparam logic [CNT_W-1:0] c_iters   = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    // State and datapath registers
    logic [1:0]         r_state_q,     w_state_d;
    logic [3:0]         r_op_q,        w_op_d;
    logic [WIDTH-1:0]   r_addend_q,    w_addend_d;   // multiplicand or divisor
    logic [2*WIDTH-1:0] r_acc_q,       w_acc_d;      // product, or {remainder, dividend/quotient}
    logic [CNT_W-1:0]   r_cnt_q,       w_cnt_d;
    logic [WIDTH-1:0]   r_result_q,    w_result_d;
    logic               r_is_zero_q,   w_is_zero_d;
    logic               r_is_neg_q,    w_is_neg_d;
    logic               r_illegal_q,   w_illegal_d;
    logic               r_dbz_q,       w_dbz_d;

    // Combinational helpers
    logic               w_accept;
    logic [SH_W-1:0]    w_shamt;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_in_is_iter;
    logic               w_in_is_mul;
    logic               w_in_is_illegal;
    logic               w_run_is_mul;
    logic               w_run_is_high;
    logic [WIDTH-1:0]   w_mul_addend;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic               w_fits;
    logic [2*WIDTH-1:0] w_acc_step;
    logic [WIDTH-1:0]   w_final;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= c_idle;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_idle: begin
                if (w_accept) begin
                    w_state_d = w_in_is_iter ? c_busy : c_done;
                end
            end
            c_busy: begin
                if (r_cnt_q == c_cnt_one) begin
                    w_state_d = c_done;
                end
            end
            c_done: begin
                if (out_ready) begin
                    w_state_d = c_idle;
                end
            end
            default: w_state_d = c_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        in_ready    = (r_state_q == c_idle);
        out_valid   = (r_state_q == c_done);
        result      = r_result_q;
        is_zero     = r_is_zero_q;
        is_negative = r_is_neg_q;
        illegal_op  = r_illegal_q;
        div_by_zero = r_dbz_q;
    end

    assign w_accept = in_valid & in_ready;

    // ------------------------------------------------------------------
    // Single-cycle ALU, evaluated on the live operands at the accept edge
    // ------------------------------------------------------------------
    always_comb begin
        w_shamt   = operand_b[SH_W-1:0];
        w_alu_res = '0;
        case (op)
            c_op_add:  w_alu_res = operand_a + operand_b;
            c_op_sub:  w_alu_res = operand_a - operand_b;
            c_op_and:  w_alu_res = operand_a & operand_b;
            c_op_or:   w_alu_res = operand_a | operand_b;
            c_op_xor:  w_alu_res = operand_a ^ operand_b;
            c_op_slt:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
            c_op_sltu: w_alu_res = {{(WIDTH-1){1'b0}}, (operand_a < operand_b)};
            c_op_sll:  w_alu_res = operand_a << w_shamt;
            c_op_srl:  w_alu_res = operand_a >> w_shamt;
            c_op_sra:  w_alu_res = WIDTH'($signed(operand_a) >>> w_shamt);
            default:   w_alu_res = '0;   // iterative and illegal ops
        endcase
    end

    always_comb begin
        w_in_is_iter    = (op >= c_op_mul) && (op <= c_op_remu);
        w_in_is_mul     = (op == c_op_mul) || (op == c_op_mulhu);
        w_in_is_illegal = (op > c_op_remu);
        w_run_is_mul    = (r_op_q == c_op_mul) || (r_op_q == c_op_mulhu);
        // MULHU and REMU both take the upper half of the accumulator
        w_run_is_high   = (r_op_q == c_op_mulhu) || (r_op_q == c_op_remu);
    end

    // ------------------------------------------------------------------
    // One multiply or divide step
    // ------------------------------------------------------------------
    always_comb begin
        // Multiply: the multiplier sits in the low half and is consumed from
        // its LSB; the partial product accumulates into the high half and the
        // whole register shifts right once per step.
        w_mul_addend = r_acc_q[0] ? r_addend_q : '0;
        w_mul_sum    = {1'b0, r_acc_q[2*WIDTH-1:WIDTH]} + {1'b0, w_mul_addend};

        // Restoring divide: shift the next dividend bit (MSB first) into the
        // partial remainder and subtract the divisor if it fits. A set MSB in
        // the shifted remainder always means the divisor fits. A zero divisor
        // always fits, so quotient becomes all ones and the remainder ends up
        // holding the whole dividend.
        w_rem_sh = {r_acc_q[2*WIDTH-1:WIDTH], r_acc_q[WIDTH-1]};
        w_diff   = w_rem_sh - {1'b0, r_addend_q};
        w_fits   = w_rem_sh[WIDTH] | ~w_diff[WIDTH];

        if (w_run_is_mul) begin
            w_acc_step = {w_mul_sum, r_acc_q[WIDTH-1:1]};
        end else begin
            w_acc_step = {(w_fits ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                          r_acc_q[WIDTH-2:0], w_fits};
        end

        w_final = w_run_is_high ? w_acc_step[2*WIDTH-1:WIDTH] : w_acc_step[WIDTH-1:0];
    end

    // ------------------------------------------------------------------
    // Datapath next-value logic
    // ------------------------------------------------------------------
    always_comb begin
        w_op_d      = r_op_q;
        w_addend_d  = r_addend_q;
        w_acc_d     = r_acc_q;
        w_cnt_d     = r_cnt_q;
        w_result_d  = r_result_q;
        w_is_zero_d = r_is_zero_q;
        w_is_neg_d  = r_is_neg_q;
        w_illegal_d = r_illegal_q;
        w_dbz_d     = r_dbz_q;

        case (r_state_q)
            c_idle: begin
                if (w_accept) begin
                    w_op_d      = op;
                    w_illegal_d = 1'b0;
                    w_dbz_d     = 1'b0;
                    if (w_in_is_iter) begin
                        w_acc_d    = {{WIDTH{1'b0}}, (w_in_is_mul ? operand_b : operand_a)};
                        w_addend_d = w_in_is_mul ? operand_a : operand_b;
                        w_cnt_d    = c_iters;
                    end else begin
                        // Illegal ops fall through the ALU as zero
                        w_result_d  = w_alu_res;
                        w_is_zero_d = (w_alu_res == '0);
                        w_is_neg_d  = w_alu_res[WIDTH-1];
                        w_illegal_d = w_in_is_illegal;
                    end
                end
            end
            c_busy: begin
                w_acc_d = w_acc_step;
                w_cnt_d = r_cnt_q - c_cnt_one;
                // The last step's outcome is registered directly as the result
                if (r_cnt_q == c_cnt_one) begin
                    w_result_d  = w_final;
                    w_is_zero_d = (w_final == '0);
                    w_is_neg_d  = w_final[WIDTH-1];
                    w_dbz_d     = !w_run_is_mul && (r_addend_q == '0);
                end
            end
            default: ;   // DONE holds everything until the consumer accepts
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_q      <= '0;
            r_addend_q  <= '0;
            r_acc_q     <= '0;
            r_cnt_q     <= '0;
            r_result_q  <= '0;
            r_is_zero_q <= 1'b0;
            r_is_neg_q  <= 1'b0;
            r_illegal_q <= 1'b0;
            r_dbz_q     <= 1'b0;
        end else begin
            r_op_q      <= w_op_d;
            r_addend_q  <= w_addend_d;
            r_acc_q     <= w_acc_d;
            r_cnt_q     <= w_cnt_d;
            r_result_q  <= w_result_d;
            r_is_zero_q <= w_is_zero_d;
            r_is_neg_q  <= w_is_neg_d;
            r_illegal_q <= w_illegal_d;
            r_dbz_q     <= w_dbz_d;
        end
    end

endmodule
`default_nettype wire
